mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Byte-wide memory and I/O responder on the far side of the CPU's `mem_a`/`mem_wr`/`mem_dout`/`mem_din` bus. It answers every CPU bus cycle with single-cycle registered read data from on-chip RAM or the memory-mapped I/O window at `mem_a[17:16]==2'b11`. It also buffers UART traffic in RX/TX FIFOs, drives `io_buffer_full` back to the CPU, and provides the cycle counter and program-stop flag.

## Interface
- `RAM_ADDR_W`, default 17: RAM byte-address width (128 KB).
- `FIFO_AW`, default 4: log2 of RX and TX FIFO depth (16 entries).
- `FULL_MARGIN`, default 2: `io_buffer_full` asserts when TX free slots ≤ this value.

- `clk_in`: in, 1 bit, system clock, the only clock.
- `rst_in`: in, 1 bit, synchronous, active-high reset.
- `mem_a`: in, 32 bits, byte address from CPU; bits 17:0 are decoded.
- `mem_wr`: in, 1 bit, 1 = write this cycle, 0 = read this cycle.
- `mem_dout`: in, 8 bits, CPU write data.
- `mem_din`: out, 8 bits, read data to CPU, registered.
- `io_buffer_full`: out, 1 bit, TX FIFO nearly full.
- `rx_data`: in, 8 bits, byte from UART receiver.
- `rx_valid`: in, 1 bit, `rx_data` valid this cycle.
- `rx_ready`: out, 1 bit, RX FIFO not full.
- `tx_data`: out, 8 bits, head of TX FIFO.
- `tx_valid`: out, 1 bit, TX FIFO not empty.
- `tx_ready`: in, 1 bit, UART transmitter accepts `tx_data`.
- `tx_overflow`: out, 1 bit, sticky flag; a TX byte was dropped.
- `program_done`: out, 1 bit, sticky flag; stop write seen.

## Operation
- Decode: `mem_a[17:16]==2'b11` selects I/O. Otherwise the RAM is addressed at `mem_a[RAM_ADDR_W-1:0]`.
- Every cycle is a bus cycle. `mem_wr=0` is a read, and there is no idle state.
- RAM write stores `mem_dout`.
- RAM read returns the byte on `mem_din` in the next cycle.
- I/O address 0x30000:
  - Read pops the RX FIFO head and returns it. If the FIFO is empty, the read returns 0x00 and no pop occurs.
  - Each read cycle pops once. The CPU holds 0x30000 for exactly one cycle per byte.
- Write to 0x30000 with data ≠ 0x00 pushes to the TX FIFO.
  - Data 0x00 is ignored.
  - A push into a full FIFO is dropped and sets `tx_overflow`.
- 32-bit cycle counter: reset to 0, increments every cycle, wraps at 2^32.
- Counter reads:
  - Read of 0x30004 returns `counter[7:0]` and copies the full counter into `snap`.
  - Reads of 0x30005, 0x30006 and 0x30007 return `snap[15:8]`, `snap[23:16]` and `snap[31:24]`.
  - Result: a 4-byte read is tear-free.
- Write to 0x30004 of any data sets `program_done`. It stays set until reset.
- Any other I/O address: read returns 0x00, write is ignored.
- FIFOs:
  - Circular buffers with FIFO_AW+1-bit pointers; full/empty is distinguished by the MSB.
  - Simultaneous push and pop is legal in every state, including full and empty. A push plus pop on a full FIFO keeps it full and accepts the push.
  - RX push occurs on `rx_valid && rx_ready`; otherwise the byte is dropped.
  - TX pop occurs on `tx_valid && tx_ready`.
- Reset values:
  - `mem_din`=0x00, `tx_valid`=0, `rx_ready`=1, `io_buffer_full`=0, `tx_overflow`=0, `program_done`=0.
  - Counter, `snap` and both FIFO pointers are 0.
  - RAM contents are not cleared.
- Reset mid-operation discards FIFO contents and any pending read data.

## Timing
- Read latency is exactly 1 cycle: address in cycle N gives `mem_din` valid in cycle N+1. `mem_din` holds until the next clock edge.
- Write takes effect at the end of cycle N. A read of the same RAM address in cycle N+1 returns the new byte.
- Counter value returned for a read in cycle N is the counter value during cycle N. The first cycle after reset deasserts reads 0.
- `io_buffer_full`, `rx_ready` and `tx_valid` are combinational from registered FIFO state. They update the cycle after a push or pop.
- `io_buffer_full` = (TX count ≥ 2^FIFO_AW − FULL_MARGIN).
- A TX push in cycle N is visible on `tx_valid`/`tx_data` in cycle N+1.
- An RX push in cycle N is poppable by a 0x30000 read in cycle N+1. It is not poppable in the same cycle.

## Configuration
- `MEM_IO_RX_EN` defined: the RX FIFO is built and 0x30000 reads behave as above.
- `MEM_IO_RX_EN` undefined:
  - No RX FIFO is built.
  - 0x30000 reads return 0x00.
  - `rx_ready` is tied to 0 and `rx_data`/`rx_valid` are ignored.

## Test plan
- RAM round trip: write 0xA5 to 0x00010, then read 0x00010 the next cycle → `mem_din`=0xA5 one cycle later. Reading an unwritten address after reset returns initialized contents; the result is checked against a preload.
- TX path, with `tx_ready`=0:
  - Write 0x48, 0x00, 0x69 to 0x30000 → exactly 2 entries.
  - Raise `tx_ready` → `tx_data` sequence 0x48, 0x69, then `tx_valid`=0.
- TX full, with `tx_ready`=0:
  - 14 pushes → `io_buffer_full`=1.
  - 16 pushes → FIFO full.
  - 17th push → dropped and `tx_overflow`=1.
  - A simultaneous push+pop while full keeps count 16.
- Counter, 6 cycles after reset: read 0x30004, 0x30005, 0x30006, 0x30007 on consecutive cycles → bytes 0x06, 0x00, 0x00, 0x00. Preload the counter to 0x000000FF via force, then read 0x30004/0x30005 → 0xFF, 0x00 with no tear.
- RX (`MEM_IO_RX_EN`):
  - Push 0x31 and 0x32 via `rx_valid`, then read 0x30000 twice → 0x31, 0x32.
  - A third read → 0x00.
  - With the macro undefined, all three reads → 0x00 and `rx_ready`=0.
- Stop and reset:
  - Write 0x00 to 0x30004 → `program_done`=1 next cycle.
  - Assert `rst_in` with TX FIFO non-empty → `program_done`=0, `tx_valid`=0, counter=0 in the following cycle.

Source files
------------

// File: rtl/mem_io_responder.sv
// Byte RAM plus I/O window at mem_a[17:16]==2'b11, answering every CPU bus cycle with 1-cycle registered read data.
// TX FIFO drops pushes when full (sticky tx_overflow); RX FIFO only exists when MEM_IO_RX_EN is defined.

module mem_io_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          drop
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module mem_io_responder #(
    parameter int RAM_ADDR_W  = 17,
    parameter int FIFO_AW     = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_overflow,
    output logic        program_done
);
    localparam logic [FIFO_AW:0] FULL_TH = (FIFO_AW+1)'((2**FIFO_AW) - FULL_MARGIN);

    logic [7:0]       ram [2**RAM_ADDR_W];
    logic [31:0]      cnt;
    logic [31:8]      snap;
    logic             io_sel, sel_data, sel_cnt;
    logic [7:0]       rd_byte, rx_byte;
    logic             tx_push, tx_pop, tx_drop, tx_empty, unused_tx_full;
    logic [FIFO_AW:0] tx_count;
    logic             unused_addr;

    assign io_sel      = (mem_a[17:16] == 2'b11);
    assign sel_data    = io_sel && (mem_a[15:0] == 16'h0000);
    assign sel_cnt     = io_sel && (mem_a[15:0] == 16'h0004);
    assign unused_addr = ^mem_a[31:18];

    assign tx_push        = mem_wr && sel_data && (mem_dout != 8'h00);
    assign tx_valid       = !tx_empty;
    assign tx_pop         = tx_valid && tx_ready;
    assign io_buffer_full = (tx_count >= FULL_TH);

    mem_io_fifo #(.AW(FIFO_AW), .W(8)) u_tx (
        .clk(clk_in), .rst(rst_in), .push(tx_push), .push_dat(mem_dout), .pop(tx_pop),
        .head(tx_data), .count(tx_count), .full(unused_tx_full), .empty(tx_empty), .drop(tx_drop)
    );

`ifdef MEM_IO_RX_EN
    logic             rx_empty, rx_full, rx_pop, unused_rx_drop;
    logic [7:0]       rx_head;
    logic [FIFO_AW:0] unused_rx_count;

    assign rx_ready = !rx_full;
    assign rx_pop   = !mem_wr && sel_data && !rx_empty;
    assign rx_byte  = rx_empty ? 8'h00 : rx_head;

    mem_io_fifo #(.AW(FIFO_AW), .W(8)) u_rx (
        .clk(clk_in), .rst(rst_in), .push(rx_valid && rx_ready), .push_dat(rx_data), .pop(rx_pop),
        .head(rx_head), .count(unused_rx_count), .full(rx_full), .empty(rx_empty), .drop(unused_rx_drop)
    );
`else
    logic unused_rx;

    assign rx_ready  = 1'b0;
    assign rx_byte   = 8'h00;
    assign unused_rx = ^{rx_data, rx_valid};
`endif

    always_comb begin
        rd_byte = ram[mem_a[RAM_ADDR_W-1:0]];
        if (io_sel) begin
            case (mem_a[15:0])
                16'h0000: rd_byte = rx_byte;
                16'h0004: rd_byte = cnt[7:0];
                16'h0005: rd_byte = snap[15:8];
                16'h0006: rd_byte = snap[23:16];
                16'h0007: rd_byte = snap[31:24];
                default:  rd_byte = 8'h00;
            endcase
        end
    end

    // The low counter byte is returned live; upper bytes come from the snapshot taken at that read.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din      <= 8'h00;
            cnt          <= '0;
            snap         <= '0;
            tx_overflow  <= 1'b0;
            program_done <= 1'b0;
        end else begin
            mem_din <= mem_wr ? 8'h00 : rd_byte;
            cnt     <= cnt + 32'd1;
            if (!mem_wr && sel_cnt) snap <= cnt[31:8];
            if (tx_drop) tx_overflow <= 1'b1;
            if (mem_wr && sel_cnt) program_done <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (mem_wr && !io_sel) ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX/RX FIFOs, counter snapshot, stop flag and reset.
module tb_mem_io_responder;
`ifdef MEM_IO_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_overflow;
    logic        program_done;

    int nchk = 0;
    int nerr = 0;
    int n;
    logic [7:0] last;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_overflow(tx_overflow), .program_done(program_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
        mem_wr   = wr;
        mem_a    = a;
        mem_dout = d;
        cyc();
    endtask

    initial begin
        rst_in = 1'b1; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        cyc(); cyc();
        chk("rst_mem_din", mem_din, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, RX_EN);
        chk("rst_io_full", io_buffer_full, 1'b0);
        chk("rst_tx_ovf", tx_overflow, 1'b0);
        chk("rst_done", program_done, 1'b0);

        // Counter: cycle 0 is the first cycle after reset releases.
        rst_in = 1'b0;
        repeat (6) cyc();
        bus(1'b0, 32'h30004, 8'h00); chk("cnt_b0", mem_din, 8'h06);
        bus(1'b0, 32'h30005, 8'h00); chk("cnt_b1", mem_din, 8'h00);
        bus(1'b0, 32'h30006, 8'h00); chk("cnt_b2", mem_din, 8'h00);
        bus(1'b0, 32'h30007, 8'h00); chk("cnt_b3", mem_din, 8'h00);
        force dut.cnt = 32'h0000_00FF;
        bus(1'b0, 32'h30004, 8'h00); chk("cnt_ff_b0", mem_din, 8'hFF);
        release dut.cnt;
        bus(1'b0, 32'h30005, 8'h00); chk("cnt_ff_b1_notear", mem_din, 8'h00);

        // RAM round trip, plus bytes kept for the post-reset check.
        bus(1'b1, 32'h00010, 8'hA5);
        bus(1'b0, 32'h00010, 8'h00); chk("ram_rt", mem_din, 8'hA5);
        bus(1'b1, 32'h00123, 8'h5C);
        bus(1'b1, 32'h1FFFF, 8'h77);
        bus(1'b0, 32'h1FFFF, 8'h00); chk("ram_top", mem_din, 8'h77);

        // TX path: zero byte is not queued.
        bus(1'b1, 32'h30000, 8'h48);
        chk("tx_first_vld", tx_valid, 1'b1);
        chk("tx_first_dat", tx_data, 8'h48);
        bus(1'b1, 32'h30000, 8'h00);
        bus(1'b1, 32'h30000, 8'h69);
        mem_wr = 1'b0; mem_a = 32'h0;
        tx_ready = 1'b1;
        chk("tx_head0", tx_data, 8'h48);
        cyc();
        chk("tx_head1", tx_data, 8'h69);
        chk("tx_vld1", tx_valid, 1'b1);
        cyc();
        chk("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // TX full handling.
        for (int i = 1; i <= 13; i++) bus(1'b1, 32'h30000, 8'(i));
        chk("tx13_not_full", io_buffer_full, 1'b0);
        bus(1'b1, 32'h30000, 8'd14);
        chk("tx14_full", io_buffer_full, 1'b1);
        bus(1'b1, 32'h30000, 8'd15);
        bus(1'b1, 32'h30000, 8'd16);
        chk("tx16_no_ovf", tx_overflow, 1'b0);
        bus(1'b1, 32'h30000, 8'hEE);
        chk("tx17_ovf", tx_overflow, 1'b1);
        tx_ready = 1'b1;
        bus(1'b1, 32'h30000, 8'hDD);
        chk("tx_pushpop_head", tx_data, 8'd2);
        mem_wr = 1'b0; mem_a = 32'h0;
        n = 0; last = 8'h00;
        for (int k = 0; k < 20; k++) begin
            if (tx_valid) begin
                n++;
                last = tx_data;
            end
            cyc();
        end
        chk("tx_full_count", n, 16);
        chk("tx_full_last", last, 8'hDD);
        chk("tx_empty_not_full", io_buffer_full, 1'b0);
        tx_ready = 1'b0;

        // RX path; a byte pushed in the read cycle is not yet visible.
        rx_valid = 1'b1; rx_data = 8'h31; cyc();
        rx_data = 8'h32; cyc();
        rx_valid = 1'b0;
        bus(1'b0, 32'h30000, 8'h00); chk("rx_rd0", mem_din, RX_EN ? 8'h31 : 8'h00);
        bus(1'b0, 32'h30000, 8'h00); chk("rx_rd1", mem_din, RX_EN ? 8'h32 : 8'h00);
        rx_valid = 1'b1; rx_data = 8'h33;
        bus(1'b0, 32'h30000, 8'h00); chk("rx_rd_empty", mem_din, 8'h00);
        rx_valid = 1'b0;
        bus(1'b0, 32'h30000, 8'h00); chk("rx_rd_late", mem_din, RX_EN ? 8'h33 : 8'h00);
        bus(1'b0, 32'h30000, 8'h00); chk("rx_rd_empty2", mem_din, 8'h00);
        chk("rx_ready", rx_ready, RX_EN);

        // Unmapped I/O address, then stop write.
        bus(1'b1, 32'h30008, 8'h55);
        bus(1'b0, 32'h30008, 8'h00); chk("io_other_rd", mem_din, 8'h00);
        chk("done_still_0", program_done, 1'b0);
        bus(1'b1, 32'h30004, 8'h00);
        chk("done_set", program_done, 1'b1);

        // Reset with TX non-empty.
        bus(1'b1, 32'h30000, 8'h41);
        chk("pre_rst_tx_vld", tx_valid, 1'b1);
        chk("pre_rst_tx_dat", tx_data, 8'h41);
        rst_in = 1'b1;
        bus(1'b0, 32'h00000, 8'h00);
        chk("rst2_done", program_done, 1'b0);
        chk("rst2_tx_vld", tx_valid, 1'b0);
        chk("rst2_tx_ovf", tx_overflow, 1'b0);
        chk("rst2_din", mem_din, 8'h00);
        rst_in = 1'b0;
        bus(1'b0, 32'h30004, 8'h00); chk("rst2_cnt0", mem_din, 8'h00);
        bus(1'b0, 32'h00123, 8'h00); chk("ram_kept_123", mem_din, 8'h5C);
        bus(1'b0, 32'h00010, 8'h00); chk("ram_kept_010", mem_din, 8'hA5);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
